mist1032isa_arbiter_matching_queue_mc: RTL and testbench
========================================================

Name: mist1032isa_arbiter_matching_queue_mc

Overview:
Multi-channel, parametrised ordered matching queue for the memory/bus arbiters. On each granted request it records which requester channel issued it, plus a per-request flag. The response side pops the head entry and gets a one-hot channel select, so responses are routed back in issue order. Compared with the single-channel queue it adds:
- channel ID storage
- occupancy count and almost-full outputs
- simultaneous push-at-full with pop
- a flush that also rewinds the pointers
- sticky overflow/underflow error flags

Parameters:
D, 8, queue depth in entries; must equal 2**DN.
DN, 3, log2(D); pointer index width.
FN, 1, flag width per entry.
CH, 4, number of requester channels.
CHN, 2, channel ID width; CH <= 2**CHN.
AF, 6, almost-full threshold in entries (1 <= AF <= D).

Ports:
iCLOCK  in  1  clock; all state on rising edge.
iRESET  in  1  reset; asynchronous, active-high.
iFLASH  in  1  synchronous flush.
iWR_REQ  in  1  push request.
iWR_CH  in  CHN  requester channel ID to record.
iWR_FLAG  in  FN  flag to record.
oWR_FULL  out  1  count == D.
oWR_ALMOST_FULL  out  1  count >= AF.
iRD_REQ  in  1  pop request.
oRD_VALID  out  1  head entry valid.
oRD_CH  out  CHN  head channel ID.
oRD_CH_ONEHOT  out  CH  one-hot decode of oRD_CH.
oRD_FLAG  out  FN  head flag.
oRD_EMPTY  out  1  count == 0.
oCOUNT  out  DN+1  current occupancy, 0..D.
oERR_OVERFLOW  out  1  sticky: push rejected.
oERR_UNDERFLOW  out  1  sticky: pop on empty.

Behaviour:
- State:
  - wr_ptr and rd_ptr are DN+1 bits each; the index is ptr[DN-1:0] and the pointers wrap modulo 2D.
  - count register, DN+1 bits.
  - Storage array of D x {CHN+FN}. It has no reset and is never read while empty.
- Reset (iRESET=1, asynchronous):
  - Pointers, count and errors go to 0.
  - Outputs: oWR_FULL=0, oWR_ALMOST_FULL=0, oRD_EMPTY=1, oRD_VALID=0, oCOUNT=0.
  - oRD_CH, oRD_FLAG and oRD_CH_ONEHOT are 0.
  - Reset mid-operation discards all entries.
- Acceptance (combinational, same cycle):
  - rd_acc = iRD_REQ && !empty && !iFLASH.
  - wr_acc = iWR_REQ && !iFLASH && (!full || rd_acc). A push at full is accepted when a pop is accepted in the same cycle.
- Update at the clock edge:
  - wr_acc: entry[wr_ptr] <= {iWR_CH, iWR_FLAG}, wr_ptr+1.
  - rd_acc: rd_ptr+1.
  - count: +1 if wr_acc only, -1 if rd_acc only, unchanged if both or neither.
- Latency and ordering:
  - A pushed entry becomes visible at the head one cycle after the push. There is no same-cycle bypass, so a push to an empty queue gives oRD_VALID=1 on the next cycle.
  - Strict FIFO order is preserved across pointer wrap-around.
- Head outputs:
  - Combinational from the registered rd_ptr and count.
  - oRD_VALID = !empty && !iFLASH.
  - When empty, oRD_CH, oRD_FLAG and oRD_CH_ONEHOT are forced to 0.
  - oRD_CH_ONEHOT has bit oRD_CH set when valid. An ID >= CH decodes to all zeros.
- Flush (iFLASH=1, synchronous, highest priority):
  - At the edge: pointers and count go to 0, and both sticky errors clear.
  - Push and pop requests in the flush cycle are ignored and do not set errors.
  - oRD_VALID is 0 during the flush cycle.
- Errors (sticky until reset or flush):
  - oERR_OVERFLOW sets when iWR_REQ && !wr_acc && !iFLASH.
  - oERR_UNDERFLOW sets when iRD_REQ && empty && !iFLASH.
- Flags:
  - oWR_FULL, oRD_EMPTY and oWR_ALMOST_FULL are decoded from the registered count only. They never depend combinationally on the request inputs.

Decomposition:
- Shared package/header mist1032isa_matching_queue_pkg:
  - a clog2-style width constant function
  - the reset value for the flag field
  - a parameter-legality check (D == 2**DN, CH <= 2**CHN, AF range), used for elaboration-time assertions
- One sub-module, mist1032isa_onehot_decoder #(CHN, CH): maps the channel ID to the one-hot select with a valid gate. It is reused by the arbiter response routers.

Test Plan:
- Reset, then push 3 entries ch=2/flag=1, ch=0/flag=0, ch=3/flag=1, one per cycle, then pop each -> oCOUNT 1,2,3 then 2,1,0; head reads CH=2 (ONEHOT=0100), CH=0 (0001), CH=3 (1000) in order; oRD_VALID=0 and oRD_EMPTY=1 after the last pop.
- Fill 8 entries (D=8, AF=6) -> oWR_ALMOST_FULL=1 from count 6, oWR_FULL=1 at 8; a 9th push alone sets oERR_OVERFLOW=1 and count stays 8; push+pop in the same cycle at full -> accepted, count stays 8, FIFO order intact.
- Pop on empty queue -> oERR_UNDERFLOW=1, pointers unchanged; errors remain 1 until iFLASH=1 for one cycle clears both.
- Push 5 entries, then assert iFLASH with iWR_REQ=1 and iRD_REQ=1 -> oRD_VALID=0 in that cycle, oCOUNT=0 next cycle, no errors set; a new push then appears at the head with the pushed CH/FLAG one cycle later.
- Run 20 push/pop pairs with a random lag of 0..7 across pointer wrap -> output sequence matches the reference model, oCOUNT never exceeds 8.
- Assert iRESET asynchronously mid-cycle with 4 entries held -> outputs immediately take their reset values (EMPTY=1, COUNT=0, VALID=0), no waiting for a clock edge.

Source files
------------

// File: rtl/mist1032isa_matching_queue_pkg.sv
// Shared constants and elaboration-time helpers for the ordered matching queues.
// Imported by the queue top and the one-hot decoder.
package mist1032isa_matching_queue_pkg;

   // Reset value for each bit of the per-entry flag field.
   localparam logic FLAG_RST_BIT = 1'b0;

   function automatic int clog2w(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction

   function automatic bit params_legal(input int d, input int dn, input int fn,
                                       input int ch, input int chn, input int af);
      return (d == (1 << dn)) && (clog2w(d) == dn) && (fn >= 1) &&
             (ch >= 1) && (ch <= (1 << chn)) && (af >= 1) && (af <= d);
   endfunction

endpackage

// File: rtl/mist1032isa_onehot_decoder.sv
// Channel ID to one-hot select with a valid gate; IDs at or beyond CH decode to zero.
// Shared with the arbiter response routers.
module mist1032isa_onehot_decoder
   import mist1032isa_matching_queue_pkg::*;
#(
   parameter int CHN = 2,
   parameter int CH  = 4
)(
   input  logic           iVALID,
   input  logic [CHN-1:0] iID,
   output logic [CH-1:0]  oONEHOT
);

   always_comb begin
      oONEHOT = '0;
      for (int i = 0; i < CH; i++) begin
         if (iVALID && (iID == CHN'(i))) begin
            oONEHOT[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mist1032isa_arbiter_matching_queue_mc.sv
// Multi-channel ordered matching queue: records the issuing channel and a flag per granted
// request, and presents the oldest entry with a one-hot route select for the response path.
module mist1032isa_arbiter_matching_queue_mc
   import mist1032isa_matching_queue_pkg::*;
#(
   parameter int D   = 8,
   parameter int DN  = 3,
   parameter int FN  = 1,
   parameter int CH  = 4,
   parameter int CHN = 2,
   parameter int AF  = 6
)(
   input  logic           iCLOCK,
   input  logic           iRESET,
   input  logic           iFLASH,
   input  logic           iWR_REQ,
   input  logic [CHN-1:0] iWR_CH,
   input  logic [FN-1:0]  iWR_FLAG,
   output logic           oWR_FULL,
   output logic           oWR_ALMOST_FULL,
   input  logic           iRD_REQ,
   output logic           oRD_VALID,
   output logic [CHN-1:0] oRD_CH,
   output logic [CH-1:0]  oRD_CH_ONEHOT,
   output logic [FN-1:0]  oRD_FLAG,
   output logic           oRD_EMPTY,
   output logic [DN:0]    oCOUNT,
   output logic           oERR_OVERFLOW,
   output logic           oERR_UNDERFLOW
);

   if (!params_legal(D, DN, FN, CH, CHN, AF)) begin : g_bad_params
      $fatal(1, "mist1032isa_arbiter_matching_queue_mc: illegal parameter set");
   end

   logic [DN:0]         wr_ptr_q, wr_ptr_d;
   logic [DN:0]         rd_ptr_q, rd_ptr_d;
   logic [DN:0]         count_q, count_d;
   logic                err_ovf_q, err_ovf_d;
   logic                err_udf_q, err_udf_d;
   logic [CHN+FN-1:0]   mem_q [D];
   logic [CHN+FN-1:0]   head;
   logic                empty, full;
   logic                rd_acc, wr_acc;

   // Status flags come from the registered count only, never from this cycle's requests.
   assign empty = (count_q == '0);
   assign full  = (count_q == (DN+1)'(D));

   always_comb begin
      rd_acc    = iRD_REQ && !empty && !iFLASH;
      wr_acc    = iWR_REQ && !iFLASH && (!full || rd_acc);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_ovf_d = err_ovf_q || (iWR_REQ && !wr_acc);
      err_udf_d = err_udf_q || (iRD_REQ && empty);
      if (iFLASH) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         err_ovf_d = 1'b0;
         err_udf_d = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + (DN+1)'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + (DN+1)'(1);
         if (wr_acc && !rd_acc) count_d = count_q + (DN+1)'(1);
         if (rd_acc && !wr_acc) count_d = count_q - (DN+1)'(1);
      end
   end

   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_ovf_q <= 1'b0;
         err_udf_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_ovf_q <= err_ovf_d;
         err_udf_q <= err_udf_d;
      end
   end

   // Storage is unreset; the head is masked whenever the queue is empty.
   always_ff @(posedge iCLOCK) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[DN-1:0]] <= {iWR_CH, iWR_FLAG};
      end
   end

   assign head            = mem_q[rd_ptr_q[DN-1:0]];
   assign oRD_VALID       = !empty && !iFLASH;
   assign oRD_CH          = empty ? '0 : head[CHN+FN-1:FN];
   assign oRD_FLAG        = empty ? {FN{FLAG_RST_BIT}} : head[FN-1:0];
   assign oRD_EMPTY       = empty;
   assign oWR_FULL        = full;
   assign oWR_ALMOST_FULL = (count_q >= (DN+1)'(AF));
   assign oCOUNT          = count_q;
   assign oERR_OVERFLOW   = err_ovf_q;
   assign oERR_UNDERFLOW  = err_udf_q;

   mist1032isa_onehot_decoder #(
      .CHN (CHN),
      .CH  (CH)
   ) u_route_dec (
      .iVALID  (oRD_VALID),
      .iID     (oRD_CH),
      .oONEHOT (oRD_CH_ONEHOT)
   );

endmodule

// File: tb/tb_mist1032isa_arbiter_matching_queue_mc.sv
// Directed bench for the multi-channel matching queue with a small queue model for the wrap run.
module tb_mist1032isa_arbiter_matching_queue_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       flash;
   logic       wr_req;
   logic [1:0] wr_ch;
   logic [0:0] wr_flag;
   logic       wr_full, wr_af;
   logic       rd_req;
   logic       rd_valid;
   logic [1:0] rd_ch;
   logic [3:0] rd_onehot;
   logic [0:0] rd_flag;
   logic       rd_empty;
   logic [3:0] count;
   logic       err_ovf, err_udf;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mist1032isa_arbiter_matching_queue_mc #(
      .D(8), .DN(3), .FN(1), .CH(4), .CHN(2), .AF(6)
   ) dut (
      .iCLOCK          (clk),
      .iRESET          (rst),
      .iFLASH          (flash),
      .iWR_REQ         (wr_req),
      .iWR_CH          (wr_ch),
      .iWR_FLAG        (wr_flag),
      .oWR_FULL        (wr_full),
      .oWR_ALMOST_FULL (wr_af),
      .iRD_REQ         (rd_req),
      .oRD_VALID       (rd_valid),
      .oRD_CH          (rd_ch),
      .oRD_CH_ONEHOT   (rd_onehot),
      .oRD_FLAG        (rd_flag),
      .oRD_EMPTY       (rd_empty),
      .oCOUNT          (count),
      .oERR_OVERFLOW   (err_ovf),
      .oERR_UNDERFLOW  (err_udf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] ch, input logic fl);
      wr_req  = 1'b1;
      wr_ch   = ch;
      wr_flag = fl;
      tick();
      wr_req  = 1'b0;
   endtask

   task automatic pop();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic check_head(input string tag, input logic [1:0] ch, input logic fl);
      check_eq({tag, "_valid"}, rd_valid, 1);
      check_eq({tag, "_ch"}, rd_ch, ch);
      check_eq({tag, "_onehot"}, rd_onehot, 4'b0001 << ch);
      check_eq({tag, "_flag"}, rd_flag, fl);
   endtask

   logic [2:0] model [$];
   logic [2:0] ent;
   int pushed, popped, lag, cyc;
   logic do_push, do_pop;

   initial begin
      rst = 1'b1; flash = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      wr_ch = 2'd0; wr_flag = 1'b0;
      #3;
      check_eq("rst_empty", rd_empty, 1);
      check_eq("rst_valid", rd_valid, 0);
      check_eq("rst_count", count, 0);
      check_eq("rst_full", wr_full, 0);
      check_eq("rst_af", wr_af, 0);
      check_eq("rst_ch", rd_ch, 0);
      check_eq("rst_onehot", rd_onehot, 0);
      check_eq("rst_flag", rd_flag, 0);
      check_eq("rst_errs", {err_ovf, err_udf}, 0);
      tick();
      rst = 1'b0;
      tick();

      // Basic order and one-hot routing
      push(2'd2, 1'b1); check_eq("b_cnt1", count, 1); check_head("b_h1", 2'd2, 1'b1);
      push(2'd0, 1'b0); check_eq("b_cnt2", count, 2);
      push(2'd3, 1'b1); check_eq("b_cnt3", count, 3); check_head("b_h1b", 2'd2, 1'b1);
      pop(); check_eq("b_cnt4", count, 2); check_head("b_h2", 2'd0, 1'b0);
      pop(); check_eq("b_cnt5", count, 1); check_head("b_h3", 2'd3, 1'b1);
      pop(); check_eq("b_cnt6", count, 0);
      check_eq("b_valid0", rd_valid, 0);
      check_eq("b_empty1", rd_empty, 1);
      check_eq("b_onehot0", rd_onehot, 0);

      // Fill, almost-full, overflow, push+pop at full
      for (int i = 0; i < 8; i++) begin
         push(2'(i % 4), 1'(i % 2));
         check_eq($sformatf("f_cnt%0d", i), count, i + 1);
         check_eq($sformatf("f_af%0d", i), wr_af, (i + 1) >= 6);
         check_eq($sformatf("f_full%0d", i), wr_full, (i + 1) == 8);
      end
      check_eq("f_ovf_pre", err_ovf, 0);
      push(2'd3, 1'b1);
      check_eq("f_ovf", err_ovf, 1);
      check_eq("f_cnt_ovf", count, 8);
      check_head("f_head0", 2'd0, 1'b0);
      wr_req = 1'b1; wr_ch = 2'd1; wr_flag = 1'b1; rd_req = 1'b1;
      tick();
      wr_req = 1'b0; rd_req = 1'b0;
      check_eq("f_cnt_pp", count, 8);
      check_eq("f_full_pp", wr_full, 1);
      for (int i = 1; i < 8; i++) begin
         check_head($sformatf("f_drain%0d", i), 2'(i % 4), 1'(i % 2));
         pop();
      end
      check_head("f_drain_new", 2'd1, 1'b1);
      pop();
      check_eq("f_cnt_end", count, 0);

      // Underflow, stickiness, flush clears errors
      pop();
      check_eq("u_udf", err_udf, 1);
      check_eq("u_cnt", count, 0);
      tick(); tick();
      check_eq("u_udf_sticky", err_udf, 1);
      check_eq("u_ovf_sticky", err_ovf, 1);
      flash = 1'b1; tick(); flash = 1'b0;
      check_eq("u_errs_clr", {err_ovf, err_udf}, 0);
      push(2'd2, 1'b0);
      check_head("u_ptr_ok", 2'd2, 1'b0);
      pop();

      // Flush with requests pending
      for (int i = 0; i < 5; i++) push(2'(i % 4), 1'b1);
      check_eq("fl_cnt5", count, 5);
      flash = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_ch = 2'd1; wr_flag = 1'b0;
      #1;
      check_eq("fl_valid_in", rd_valid, 0);
      tick();
      flash = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
      check_eq("fl_cnt0", count, 0);
      check_eq("fl_empty", rd_empty, 1);
      check_eq("fl_errs", {err_ovf, err_udf}, 0);
      push(2'd3, 1'b0);
      check_head("fl_new", 2'd3, 1'b0);
      pop();

      // Random-lag push/pop pairs across pointer wrap
      pushed = 0; popped = 0; cyc = 0;
      lag = $urandom_range(0, 7);
      while (popped < 20 && cyc < 400) begin
         do_push = (pushed < 20) && (model.size() < 8);
         do_pop  = (model.size() > 0) && ((model.size() > lag) || (pushed == 20));
         ent = 3'($urandom_range(0, 7));
         wr_req = do_push; wr_ch = ent[2:1]; wr_flag = ent[0];
         rd_req = do_pop;
         if (do_pop) check_head($sformatf("w_pop%0d", popped), model[0][2:1], model[0][0]);
         tick();
         wr_req = 1'b0; rd_req = 1'b0;
         if (do_pop) begin
            void'(model.pop_front());
            popped++;
            lag = $urandom_range(0, 7);
         end
         if (do_push) begin
            model.push_back(ent);
            pushed++;
         end
         check_eq($sformatf("w_cnt%0d", cyc), count, model.size());
         check_eq($sformatf("w_le8_%0d", cyc), count <= 8, 1);
         cyc++;
      end
      check_eq("w_done", popped, 20);

      // Asynchronous reset mid-cycle
      for (int i = 0; i < 4; i++) push(2'(i), 1'b1);
      check_eq("a_cnt4", count, 4);
      #2;
      rst = 1'b1;
      #1;
      check_eq("a_empty", rd_empty, 1);
      check_eq("a_cnt", count, 0);
      check_eq("a_valid", rd_valid, 0);
      check_eq("a_onehot", rd_onehot, 0);
      #10;
      rst = 1'b0;
      tick();
      check_eq("a_post_cnt", count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
